// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM states
//   INSTR_W        : instruction word width in bits
//   BYTE_W         : stream byte width in bits
//   BYTES_PER_WORD : bytes packed into one instruction word
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    localparam int INSTR_W        = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = INSTR_W / BYTE_W;

endpackage

// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs a byte stream big-endian into 32-bit words: the first byte of a word
// ends up in bits [31:24], the fourth in bits [7:0].
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_clr       discard any partial word and restart at byte 0
//   i_push      accept i_byte_in this cycle
//   i_byte_in   stream byte
//   o_word_out  packed word (registered)
//   o_full      this push completes a word; the word appears next cycle
// -----------------------------------------------------------------------------
module byte_word_packer
    import mips_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_push,
    input  logic [BYTE_W-1:0]  i_byte_in,
    output logic [INSTR_W-1:0] o_word_out,
    output logic               o_full
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]   r_byte_idx;
    logic [INSTR_W-1:0] r_word;

    // Shifting left and inserting at the bottom gives big-endian order after
    // four pushes. The index wraps naturally from 3 back to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_idx <= '0;
            r_word     <= '0;
        end else if (i_clr) begin
            r_byte_idx <= '0;
            r_word     <= '0;
        end else if (i_push) begin
            r_byte_idx <= r_byte_idx + IDX_W'(1);
            r_word     <= {r_word[INSTR_W-BYTE_W-1:0], i_byte_in};
        end
    end

    // Clear wins over push, so a word never completes in a clearing cycle.
    assign o_full     = i_push && !i_clr && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word_out = r_word;

endmodule

// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
// Writer side of the instruction memory: takes a byte stream over valid/ready,
// packs it big-endian into 32-bit words and writes them to consecutive word
// addresses starting at 0, holding the core stalled until the load completes.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          1-cycle pulse: begin load (honoured only in IDLE/DONE)
//   i_word_count     words to load, captured on start (0 .. 2**ADDR_W)
//   i_abort          cancel an in-progress load
//   i_rx_byte        stream byte
//   i_rx_valid       stream byte valid
//   o_rx_ready       loader accepts a byte this cycle (decoded from state)
//   o_imem_we        imem write strobe, one cycle per word
//   o_imem_addr      imem word address
//   o_imem_wdata     packed instruction word
//   o_core_hold      1 = core stalled
//   o_busy           load in progress
//   o_done           1-cycle pulse when the load finishes
//   o_err            sticky abort/oversize flag, cleared by next accepted start
// -----------------------------------------------------------------------------
module imem_program_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_abort,
    input  logic [7:0]        i_rx_byte,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [DATA_W-1:0] o_imem_wdata,
    output logic              o_core_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // Memory depth expressed in the word_count width (2**ADDR_W).
    localparam logic [ADDR_W:0] L_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic              r_imem_we;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W:0]   r_word_count;
    logic              r_core_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_idle_like;
    logic              w_start_zero;
    logic              w_start_over;
    logic              w_start_load;
    logic              w_abort;
    logic              w_push;
    logic              w_full;
    logic              w_last;
    logic              w_write_done;
    logic              w_enter_done;
    logic              w_clr;
    logic [INSTR_W-1:0] w_word;

    assign w_idle_like  = (r_state == IDLE) || (r_state == DONE);
    assign w_start_zero = w_idle_like && i_start && (i_word_count == '0);
    assign w_start_over = w_idle_like && i_start && (i_word_count > L_DEPTH);
    assign w_start_load = w_idle_like && i_start && (i_word_count != '0) && !w_start_over;
    assign w_abort      = i_abort && ((r_state == COLLECT) || (r_state == WRITE));

    // Abort takes priority over a byte presented in the same cycle.
    assign w_push       = (r_state == COLLECT) && i_rx_valid && !i_abort;
    assign w_clr        = w_start_load || w_abort;

    assign w_last       = ({1'b0, r_word_idx} + (ADDR_W + 1)'(1)) == r_word_count;
    assign w_write_done = (r_state == WRITE) && !i_abort && w_last;
    assign w_enter_done = w_start_zero || w_write_done;

    byte_word_packer u_packer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_clr),
        .i_push     (w_push),
        .i_byte_in  (i_rx_byte),
        .o_word_out (w_word),
        .o_full     (w_full)
    );

    // Next-state decode. WRITE lasts exactly one cycle; an abort seen during
    // WRITE still lets that cycle's write go out because imem_we is already
    // registered high.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_start_zero)      w_next_state = DONE;
                else if (w_start_load) w_next_state = COLLECT;
            end
            COLLECT: begin
                if (i_abort)     w_next_state = IDLE;
                else if (w_full) w_next_state = WRITE;
            end
            WRITE: begin
                if (i_abort)     w_next_state = IDLE;
                else if (w_last) w_next_state = DONE;
                else             w_next_state = COLLECT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State and registered outputs. core_hold comes out of reset high so the
    // core never runs from an unloaded memory, and only drops together with
    // the done pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_imem_we    <= 1'b0;
            r_word_idx   <= '0;
            r_word_count <= '0;
            r_core_hold  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_imem_we <= w_full;
            r_done    <= w_enter_done;

            if (w_start_load) begin
                r_word_count <= i_word_count;
                r_word_idx   <= '0;
                r_err        <= 1'b0;
                r_core_hold  <= 1'b1;
                r_busy       <= 1'b1;
            end else if (w_start_zero) begin
                r_word_count <= '0;
                r_err        <= 1'b0;
                r_core_hold  <= 1'b0;
                r_busy       <= 1'b0;
            end else if (w_start_over) begin
                r_err <= 1'b1;
            end

            if (w_abort) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end

            if ((r_state == WRITE) && !i_abort && !w_last) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
            end

            if (w_write_done) begin
                r_core_hold <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign o_rx_ready   = (r_state == COLLECT);
    assign o_imem_we    = r_imem_we;
    assign o_imem_addr  = r_word_idx;
    assign o_imem_wdata = w_word;
    assign o_core_hold  = r_core_hold;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

endmodule
